// File: rtl/if_stage_btb.sv
// Instruction-fetch stage with PC register, one-entry skid buffer, IF/ID output register
// and a direct-mapped BTB (2-bit counters) that supplies the next-PC prediction.
module if_stage_btb #(
  parameter int unsigned   AW           = 32,
  parameter int unsigned   IW           = 32,
  parameter logic [AW-1:0] RESET_VECTOR = '0,
  parameter int unsigned   BTB_ENTRIES  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_pc,
  input  logic [AW-1:0] upd_target,
  input  logic          upd_taken,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic [IW-1:0] im_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pci,
  output logic          out_pred_taken,
  output logic [AW-1:0] out_pred_target
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned TW  = AW - IDX - 2;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
  } req_t;

  typedef struct packed {
    logic [IW-1:0] instr;
    req_t          req;
  } entry_t;

  logic [AW-1:0] pc;
  logic          infl_v;
  req_t          infl_q;
  logic          skid_v;
  entry_t        skid_q;
  entry_t        out_q;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TW-1:0]          btb_tag [BTB_ENTRIES];
  logic [AW-1:0]          btb_tgt [BTB_ENTRIES];
  logic [1:0]             btb_ctr [BTB_ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [TW-1:0]  lk_tag;
  logic           lk_taken;
  logic [AW-1:0]  pred_next;
  logic [IDX-1:0] up_idx;
  logic [TW-1:0]  up_tag;
  logic           up_hit;

  logic   slot_free;
  logic   stall_hold;
  logic   issue;
  logic   load;
  entry_t infl_e;
  entry_t load_e;

  // Word-offset bits of the update PC carry no BTB information.
  logic unused_upd_lsb;
  assign unused_upd_lsb = ^upd_pc[1:0];

  // BTB lookup on the current PC (reads pre-update contents).
  always_comb begin
    lk_idx    = pc[IDX+1:2];
    lk_tag    = pc[AW-1:IDX+2];
    lk_taken  = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag) && btb_ctr[lk_idx][1];
    pred_next = lk_taken ? btb_tgt[lk_idx] : pc + AW'(4);
  end

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[AW-1:IDX+2];
  assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

  // BTB training: saturating counters on hit, allocate weakly-taken on a taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[IDX'(i)] <= '0;
        btb_tgt[IDX'(i)] <= '0;
        btb_ctr[IDX'(i)] <= 2'b00;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          btb_tgt[up_idx] <= upd_target;
          if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
        end else if (btb_ctr[up_idx] != 2'b00) begin
          btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        btb_valid[up_idx] <= 1'b1;
        btb_tag[up_idx]   <= up_tag;
        btb_tgt[up_idx]   <= upd_target;
        btb_ctr[up_idx]   <= 2'b10;
      end
    end
  end

  // Issue only when the returning word is guaranteed a place (out slot or empty skid).
  assign slot_free  = !out_valid || out_ready;
  assign stall_hold = infl_v && out_valid && !out_ready;
  assign issue      = !redirect_valid && !skid_v && !stall_hold;
  assign im_req     = rst_n && issue;
  assign im_addr    = pc;

  assign infl_e = '{instr: im_rdata, req: infl_q};
  assign load   = slot_free && (skid_v || infl_v);
  assign load_e = skid_v ? skid_q : infl_e;

  // PC, in-flight, skid and output registers; a redirect flushes everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VECTOR;
      infl_v    <= 1'b0;
      infl_q    <= '0;
      skid_v    <= 1'b0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_pci   <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_target;
      infl_v    <= 1'b0;
      skid_v    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        pc     <= pred_next;
        infl_q <= '{pc: pc, pred_taken: lk_taken, pred_target: pred_next};
      end
      if (slot_free) begin
        out_valid <= load;
        if (load) begin
          out_q   <= load_e;
          out_pci <= load_e.req.pc + AW'(4);
        end
        skid_v <= skid_v && infl_v;
        if (skid_v && infl_v) skid_q <= infl_e;
      end else if (infl_v) begin
        skid_v <= 1'b1;
        skid_q <= infl_e;
      end
    end
  end

  assign out_instr       = out_q.instr;
  assign out_pc          = out_q.req.pc;
  assign out_pred_taken  = out_q.req.pred_taken;
  assign out_pred_target = out_q.req.pred_target;

endmodule
